// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port data memory between the MEM stage (port P)
// and a DMA/debug port (port D). P wins by default; D wins once it has lost STARVE_MAX
// consecutive arbitration cycles. Also steers RV32I sub-word stores onto byte lanes,
// extracts/extends sub-word loads and rejects misaligned P accesses.
module dmem_arbiter #(
    parameter int unsigned DM_ADDRESS = 9,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // MEM-stage port
    input  logic                  p_req,
    input  logic                  p_we,
    input  logic [DM_ADDRESS-1:0] p_addr,
    input  logic [DATA_W-1:0]     p_wdata,
    input  logic [2:0]            p_funct3,
    output logic                  p_gnt,
    output logic                  p_rvalid,
    output logic [DATA_W-1:0]     p_rdata,
    output logic                  p_err,
    // DMA/debug port
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DM_ADDRESS-1:0] d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [3:0]            d_be,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    // memory side
    output logic [DM_ADDRESS-1:0] m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [3:0]            m_wr,
    output logic                  m_rd,
    input  logic [DATA_W-1:0]     m_rdata
);

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    typedef enum logic {StIdle, StRdWait} state_e;

    state_e      state_q;
    logic [3:0]  starve_q;
    logic        owner_d_q;   // 1: pending read belongs to port D
    logic [1:0]  off_q;
    logic [2:0]  funct3_q;

    logic        p_is_byte;
    logic        p_is_half;
    logic        p_misal;
    logic [DATA_W-1:0] p_st_data;
    logic [3:0]  p_st_be;
    logic        p_win;
    logic        d_win;
    logic [DATA_W-1:0] ld_shift;
    logic [DATA_W-1:0] ld_ext;

    // Word offset of D accesses is ignored by design.
    logic unused_d_off;
    assign unused_d_off = ^d_addr[1:0];

    // Decode P access size, alignment and store lane steering.
    always_comb begin
        p_is_byte = 1'b0;
        p_is_half = 1'b0;
        if (p_we) begin
            case (p_funct3)
                3'b000:  p_is_byte = 1'b1;
                3'b001:  p_is_half = 1'b1;
                default: ;
            endcase
        end else begin
            case (p_funct3)
                3'b000, 3'b100: p_is_byte = 1'b1;
                3'b001, 3'b101: p_is_half = 1'b1;
                default:        ;
            endcase
        end

        if (p_is_half) begin
            p_misal = p_addr[0];
        end else if (p_is_byte) begin
            p_misal = 1'b0;
        end else begin
            p_misal = (p_addr[1:0] != 2'b00);
        end

        if (p_is_byte) begin
            p_st_data = {4{p_wdata[7:0]}};
            p_st_be   = 4'b0001 << p_addr[1:0];
        end else if (p_is_half) begin
            p_st_data = {2{p_wdata[15:0]}};
            p_st_be   = p_addr[1] ? 4'b1100 : 4'b0011;
        end else begin
            p_st_data = p_wdata;
            p_st_be   = 4'b1111;
        end
    end

    // Arbitrate in IDLE and drive the memory from the winner.
    always_comb begin
        p_win   = 1'b0;
        d_win   = 1'b0;
        p_err   = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_wr    = 4'b0000;
        m_rd    = 1'b0;

        if (rst_n && state_q == StIdle) begin
            if (d_req && (!p_req || starve_q == StarveMax)) begin
                d_win = 1'b1;
            end else if (p_req) begin
                p_win = 1'b1;
            end
        end

        if (d_win) begin
            m_addr  = {d_addr[DM_ADDRESS-1:2], 2'b00};
            m_wdata = d_wdata;
            m_wr    = d_we ? d_be : 4'b0000;
            m_rd    = !d_we;
        end else if (p_win) begin
            p_err  = p_misal;
            m_addr = {p_addr[DM_ADDRESS-1:2], 2'b00};
            if (!p_misal) begin
                if (p_we) begin
                    m_wdata = p_st_data;
                    m_wr    = p_st_be;
                end else begin
                    m_rd = 1'b1;
                end
            end
        end

        p_gnt = p_win;
        d_gnt = d_win;
    end

    // Extract and extend the P load from the returned word.
    always_comb begin
        ld_shift = m_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_ext = {24'h000000, ld_shift[7:0]};
            3'b101:  ld_ext = {16'h0000, ld_shift[15:0]};
            default: ld_ext = ld_shift;
        endcase

        p_rvalid = rst_n && state_q == StRdWait && !owner_d_q;
        d_rvalid = rst_n && state_q == StRdWait && owner_d_q;
        p_rdata  = p_rvalid ? ld_ext : '0;
        d_rdata  = d_rvalid ? m_rdata : '0;
    end

    // FSM, starvation counter and pending-read context.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            starve_q  <= 4'd0;
            owner_d_q <= 1'b0;
            off_q     <= 2'b00;
            funct3_q  <= 3'b000;
        end else begin
            case (state_q)
                StIdle: begin
                    if (d_req && !d_win) begin
                        if (starve_q != StarveMax) begin
                            starve_q <= starve_q + 4'd1;
                        end
                    end else begin
                        starve_q <= 4'd0;
                    end

                    if (d_win && !d_we) begin
                        state_q   <= StRdWait;
                        owner_d_q <= 1'b1;
                    end else if (p_win && !p_we && !p_misal) begin
                        state_q   <= StRdWait;
                        owner_d_q <= 1'b0;
                        off_q     <= p_addr[1:0];
                        funct3_q  <= p_funct3;
                    end
                end
                StRdWait: state_q <= StIdle;
                default:  state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by randomized traffic, all checked
// against a byte-addressed reference memory and a rule-level arbitration model.
module tb_dmem_arbiter;

    localparam int SMAX = 4;

    logic        clk;
    logic        rst_n;
    logic        p_req, p_we;
    logic [8:0]  p_addr;
    logic [31:0] p_wdata;
    logic [2:0]  p_funct3;
    logic        p_gnt, p_rvalid, p_err;
    logic [31:0] p_rdata;
    logic        d_req, d_we;
    logic [8:0]  d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic [8:0]  m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wr;
    logic        m_rd;
    logic [31:0] m_rdata;

    int checks;
    int failures;

    // memory seen by the DUT
    logic [31:0] mem [128];
    // reference model state
    logic [7:0]  ref_mem [512];
    bit          busy;
    bit          busy_d;
    logic [8:0]  busy_addr;
    logic [2:0]  busy_fn;
    int          lost;
    bit          exp_pg;
    bit          exp_dg;

    logic [2:0] ld_fns [5];
    logic [2:0] st_fns [3];

    dmem_arbiter #(
        .DM_ADDRESS (9),
        .DATA_W     (32),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .p_req    (p_req),
        .p_we     (p_we),
        .p_addr   (p_addr),
        .p_wdata  (p_wdata),
        .p_funct3 (p_funct3),
        .p_gnt    (p_gnt),
        .p_rvalid (p_rvalid),
        .p_rdata  (p_rdata),
        .p_err    (p_err),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_be     (d_be),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_wr     (m_wr),
        .m_rd     (m_rd),
        .m_rdata  (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port memory: read data appears the cycle after m_rd.
    always @(posedge clk) begin
        if (m_rd) m_rdata <= mem[m_addr[8:2]];
        for (int i = 0; i < 4; i++) begin
            if (m_wr[i]) mem[m_addr[8:2]][8*i +: 8] <= m_wdata[8*i +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic we, input logic [2:0] fn);
        if (fn == 3'b000 || (!we && fn == 3'b100)) return 1;
        if (fn == 3'b001 || (!we && fn == 3'b101)) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [8:0] a, input logic [2:0] fn);
        int ai;
        ai = int'(a);
        case (fn)
            3'b000:  return 32'($signed(ref_mem[ai]));
            3'b100:  return {24'h0, ref_mem[ai]};
            3'b001:  return 32'($signed({ref_mem[ai+1], ref_mem[ai]}));
            3'b101:  return {16'h0, ref_mem[ai+1], ref_mem[ai]};
            default: return {ref_mem[ai+3], ref_mem[ai+2], ref_mem[ai+1], ref_mem[ai]};
        endcase
    endfunction

    // One clock: predict from the rules, compare mid-cycle, advance the model at the edge.
    task automatic cycle();
        bit pw, dw, perr, acc_rd, e_prv, e_drv;
        logic [3:0]  ewr;
        logic [31:0] ewd;
        logic [8:0]  eaddr;
        int sz, off;
        @(negedge clk);
        pw = 0; dw = 0; perr = 0; acc_rd = 0;
        ewr = 4'b0000; ewd = 32'h0; eaddr = 9'h0;
        if (rst_n && !busy) begin
            if (d_req && (!p_req || lost >= SMAX)) dw = 1;
            else if (p_req) pw = 1;
        end
        if (dw) begin
            eaddr = d_addr & 9'h1FC;
            if (d_we) begin
                ewr = d_be;
                ewd = d_wdata;
            end else begin
                acc_rd = 1;
            end
        end
        if (pw) begin
            sz    = size_of(p_we, p_funct3);
            off   = int'(p_addr[1:0]);
            perr  = (off % sz) != 0;
            eaddr = p_addr & 9'h1FC;
            if (!perr) begin
                if (p_we) begin
                    ewr = (sz == 1) ? 4'(1 << off) : (sz == 2) ? 4'(3 << off) : 4'b1111;
                    ewd = (sz == 1) ? {4{p_wdata[7:0]}} :
                          (sz == 2) ? {2{p_wdata[15:0]}} : p_wdata;
                end else begin
                    acc_rd = 1;
                end
            end
        end
        e_prv = rst_n && busy && !busy_d;
        e_drv = rst_n && busy && busy_d;

        chk("p_gnt", 32'(p_gnt), 32'(pw));
        chk("d_gnt", 32'(d_gnt), 32'(dw));
        chk("p_err", 32'(p_err), 32'(perr));
        chk("m_wr", 32'(m_wr), 32'(ewr));
        chk("m_rd", 32'(m_rd), 32'(acc_rd));
        if (ewr != 4'b0000 || acc_rd) chk("m_addr", 32'(m_addr), 32'(eaddr));
        if (ewr != 4'b0000) chk("m_wdata", m_wdata, ewd);
        chk("p_rvalid", 32'(p_rvalid), 32'(e_prv));
        chk("d_rvalid", 32'(d_rvalid), 32'(e_drv));
        if (e_prv) chk("p_rdata", p_rdata, ref_load(busy_addr, busy_fn));
        if (e_drv) chk("d_rdata", d_rdata, ref_load(busy_addr, 3'b010));
        if (!rst_n) begin
            chk("rst_p_rdata", p_rdata, 32'h0);
            chk("rst_d_rdata", d_rdata, 32'h0);
            chk("rst_m_addr", 32'(m_addr), 32'h0);
            chk("rst_m_wdata", m_wdata, 32'h0);
        end
        exp_pg = pw;
        exp_dg = dw;

        @(posedge clk);
        if (!rst_n) begin
            busy = 0;
            lost = 0;
        end else if (busy) begin
            busy = 0;
        end else begin
            if (d_req && !dw) lost = (lost < SMAX) ? lost + 1 : lost;
            else lost = 0;
            for (int i = 0; i < 4; i++) begin
                if (ewr[i]) ref_mem[int'(eaddr) + i] = ewd[8*i +: 8];
            end
            if (acc_rd) begin
                busy      = 1;
                busy_d    = dw;
                busy_addr = dw ? eaddr : p_addr;
                busy_fn   = p_funct3;
            end
        end
        #1;
    endtask

    task automatic p_set(input logic we, input logic [8:0] a, input logic [2:0] fn,
                         input logic [31:0] wd);
        p_req = 1; p_we = we; p_addr = a; p_funct3 = fn; p_wdata = wd;
    endtask

    task automatic d_set(input logic we, input logic [8:0] a, input logic [31:0] wd,
                         input logic [3:0] be);
        d_req = 1; d_we = we; d_addr = a; d_wdata = wd; d_be = be;
    endtask

    initial begin
        checks = 0; failures = 0;
        ld_fns = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        st_fns = '{3'b000, 3'b001, 3'b010};
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        for (int i = 0; i < 512; i++) ref_mem[i] = 8'h0;
        busy = 0; busy_d = 0; busy_addr = 9'h0; busy_fn = 3'b000; lost = 0;
        m_rdata = 32'h0;
        rst_n = 0;
        p_req = 0; p_we = 0; p_addr = 9'h0; p_wdata = 32'h0; p_funct3 = 3'b000;
        d_req = 0; d_we = 0; d_addr = 9'h0; d_wdata = 32'h0; d_be = 4'h0;

        // reset with requests pending: nothing may be granted
        cycle();
        p_set(1, 9'h010, 3'b010, 32'h1111_1111);
        d_set(1, 9'h014, 32'h2222_2222, 4'hF);
        cycle();
        p_req = 0; d_req = 0;
        rst_n = 1;
        #1;

        // SW then LW
        p_set(1, 9'h010, 3'b010, 32'hDEAD_BEEF);
        #1 chk("sw_m_wr", 32'(m_wr), 32'h0000_000F);
        chk("sw_m_addr", 32'(m_addr), 32'h0000_0010);
        cycle();
        p_set(0, 9'h010, 3'b010, 32'h0);
        cycle();
        p_req = 0;
        #1 chk("lw_rdata", p_rdata, 32'hDEAD_BEEF);
        cycle();

        // SB lane steering, then LB / LBU
        p_set(1, 9'h013, 3'b000, 32'h0000_00A5);
        #1 chk("sb_m_wr", 32'(m_wr), 32'h0000_0008);
        chk("sb_m_wdata", m_wdata, 32'hA5A5_A5A5);
        cycle();
        p_set(0, 9'h013, 3'b000, 32'h0);
        cycle();
        p_req = 0;
        #1 chk("lb_rdata", p_rdata, 32'hFFFF_FFA5);
        cycle();
        p_set(0, 9'h013, 3'b100, 32'h0);
        cycle();
        p_req = 0;
        #1 chk("lbu_rdata", p_rdata, 32'h0000_00A5);
        cycle();

        // misaligned accesses
        p_set(0, 9'h011, 3'b001, 32'h0);
        #1 chk("lh_mis_err", 32'(p_err), 32'h1);
        chk("lh_mis_rd", 32'(m_rd), 32'h0);
        cycle();
        p_req = 0;
        #1 chk("lh_mis_rvalid", 32'(p_rvalid), 32'h0);
        p_set(1, 9'h012, 3'b010, 32'hCAFE_F00D);
        #1 chk("sw_mis_err", 32'(p_err), 32'h1);
        chk("sw_mis_wr", 32'(m_wr), 32'h0);
        cycle();
        p_req = 0;
        cycle();

        // starvation: P wins four times, D the fifth
        p_set(1, 9'h040, 3'b010, 32'h0404_0404);
        d_set(1, 9'h044, 32'h4444_4444, 4'hF);
        for (int i = 0; i < 5; i++) begin
            #1 chk("starve_p_gnt", 32'(p_gnt), 32'(i < 4));
            chk("starve_d_gnt", 32'(d_gnt), 32'(i == 4));
            cycle();
        end
        // counter cleared after the D grant: P wins again
        #1 chk("starve_clr_p_gnt", 32'(p_gnt), 32'h1);
        cycle();
        p_req = 0; d_req = 0;
        cycle();

        // D read wins after starvation, RD_WAIT blocks P for one cycle
        d_set(1, 9'h020, 32'h1234_5678, 4'hF);
        cycle();
        d_set(0, 9'h020, 32'h0, 4'h0);
        p_set(1, 9'h030, 3'b010, 32'h3030_3030);
        for (int i = 0; i < 4; i++) cycle();
        #1 chk("dread_d_gnt", 32'(d_gnt), 32'h1);
        chk("dread_m_rd", 32'(m_rd), 32'h1);
        cycle();
        d_req = 0;
        #1 chk("rdwait_p_gnt", 32'(p_gnt), 32'h0);
        chk("rdwait_d_rvalid", 32'(d_rvalid), 32'h1);
        chk("rdwait_d_rdata", d_rdata, 32'h1234_5678);
        cycle();
        #1 chk("after_wait_p_gnt", 32'(p_gnt), 32'h1);
        cycle();
        p_req = 0;
        cycle();

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            if (!p_req && $urandom_range(0, 2) != 0) begin
                p_req   = 1;
                p_we    = 1'($urandom_range(0, 1));
                p_funct3 = p_we ? st_fns[$urandom_range(0, 2)] : ld_fns[$urandom_range(0, 4)];
                p_addr  = 9'($urandom);
                if ($urandom_range(0, 3) != 0) p_addr[0] = 1'b0;
                p_wdata = $urandom;
            end
            if (!d_req && $urandom_range(0, 3) == 0) begin
                d_req   = 1;
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = 9'($urandom);
                d_wdata = $urandom;
                d_be    = 4'($urandom);
            end
            cycle();
            if (exp_pg) p_req = 0;
            if (exp_dg) d_req = 0;
        end
        p_req = 0; d_req = 0;
        cycle();

        // reset while a P load is pending
        p_set(0, 9'h010, 3'b010, 32'h0);
        cycle();
        p_req = 0;
        rst_n = 0;
        #1 chk("rst_wait_p_rvalid", 32'(p_rvalid), 32'h0);
        chk("rst_wait_p_rdata", p_rdata, 32'h0);
        cycle();
        rst_n = 1;
        p_set(0, 9'h010, 3'b010, 32'h0);
        #1 chk("rst_release_p_gnt", 32'(p_gnt), 32'h1);
        cycle();
        p_req = 0;
        cycle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
